pipe_out_burst_arbiter: RTL and testbench
=========================================

# pipe_out_burst_arbiter

Shares one host-facing PipeOut endpoint between `N_SRC` first-word-fall-through data sources in the `okClk` domain. Each host read stream is a sequence of framed bursts: one header word that identifies the source, then exactly `BURST` data words. When no source is ready, idle filler words are returned. Round-robin arbitration grants a source for a whole frame, and the frame is never interrupted.

## Interface
- `N_SRC`, default 4: number of sources, 1..256.
- `DW`, default 32: data width, fixed at 32 (header format depends on it).
- `BURST`, default 4: data words per frame, 1..65535.
- `okClk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `src_avail`  in  N_SRC  bit i set: source i holds at least `BURST` words.
- `src_valid`  in  N_SRC  bit i set: head word of source i is valid.
- `src_data`  in  N_SRC*DW  source i head word at `[DW*i +: DW]`.
- `src_ready`  out  N_SRC  one-cycle pop strobe to source i; combinational.
- `pipe_out_read`  in  1  host read strobe; consumes the current `pipe_out_data`.
- `pipe_out_data`  out  DW  registered word presented to the host.
- `busy`  out  1  high while a frame is in progress (state is not IDLE).
- `grant_id`  out  8  source index of the current or last frame.
- `frames_sent`  out  32  count of completed frames; wraps modulo 2^32.
- `underflow_err`  out  1  sticky; set when a pop hits a source whose `src_valid` is low.

## Operation
- **Reset values:** FSM=IDLE, `pipe_out_data`=0x0000_0000, RR pointer=0, beat counter=0, `grant_id`=0, `frames_sent`=0, `underflow_err`=0, `src_ready`=0.
- **Word formats:**
  - Idle word = 0x0000_0000.
  - Header = {1'b1, 7'b0, grant_id[7:0], BURST[15:0]}. Bit 31 marks a header.
  - Data words are forwarded unmodified; the host tells them apart by position.
- **IDLE:**
  - `pipe_out_data` holds the idle word. A read in IDLE consumes one idle word.
  - If any `src_avail` bit is set, the winner is the first set bit searched upward from the RR pointer, wrapping modulo N_SRC.
  - On that edge: latch the winner into `grant_id`, load the header into `pipe_out_data`, and go to HDR.
  - Grant happens whether or not a read occurs in the same cycle.
- **HDR:**
  - On read: `pipe_out_data` <= head word of `grant_id`, `src_ready[grant_id]`=1, beat counter <= 1, go to DATA.
  - With no read, hold.
- **DATA:**
  - On read with counter < BURST: load the next head word, pop the source, increment the counter.
  - On read with counter == BURST:
    - `pipe_out_data` <= idle word and go to IDLE.
    - RR pointer <= (grant_id+1) mod N_SRC.
    - `frames_sent`++.
    - No pop on this read.
- **Pop rule:** `src_ready[i]` = `pipe_out_read` & (state is HDR, or state is DATA with counter < BURST) & (i == `grant_id`). At most one bit is ever set.
- **Mid-frame input changes:** `src_avail` is sampled only in IDLE. Deassertion during a frame is ignored, and the frame completes.
- **Underflow:** if a pop occurs while `src_valid[grant_id]`=0, the word is loaded anyway and `underflow_err` is set until reset.
- **Reset mid-frame:** the frame is truncated, all state returns to reset values, and the host sees idle words. The host resyncs on the header bit.
- **N_SRC=1:** the RR pointer stays at 0.

## Timing
- `pipe_out_data` changes only on the `okClk` edge that follows a read, or on the IDLE→HDR grant edge.
- **Read latency:** the word consumed by a read is the value present in the same cycle as `pipe_out_read`.
- **Frame length:** exactly BURST+1 reads (header plus data), independent of read spacing. Back-to-back reads every cycle are supported.
- **Gap between frames:** at least one cycle in IDLE, which is the grant decision cycle. A read during that cycle returns the idle word.
- **Pop timing:** `src_ready` asserts in the same cycle as the read. The source advances its head on that edge.

## Test plan
- **Single source, continuous reads.** N_SRC=4, BURST=4, only src 2 avail, src 2 data 0x11..0x15, reads every cycle. Expect: idle, 0x8002_0004, 0x11, 0x12, 0x13, 0x14, idle. `frames_sent`=1, 4 pops on src 2.
- **Round-robin fairness.** All sources avail permanently. Expect headers in order src 0,1,2,3,0. Each frame has 4 data words; no source is granted twice before the others.
- **Avail drop mid-frame.** Deassert `src_avail[1]` after the first data word of a src 1 frame. Expect the frame still delivers 4 data words, then src 1 is not granted again.
- **Sparse reads.** Reads spaced 1–5 cycles apart at random. Expect the identical word sequence as continuous reads, with `pipe_out_data` stable between reads.
- **Underflow.** `src_valid[0]`=0 at the third pop. Expect `underflow_err`=1, staying 1 through later frames until `rst`.
- **Reset mid-frame.** Assert `rst` after 2 data words. Expect immediately `pipe_out_data`=0, `busy`=0, `frames_sent`=0. After release, src 0 is granted first again.

Source files
------------

// File: rtl/pipe_out_burst_arbiter.sv
// Round-robin arbiter that frames BURST words from one of N_SRC FWFT sources per host PipeOut frame.
// Registered output advances one word per host read; frames are never interrupted and sources pop in the read cycle.
module pipe_out_burst_arbiter #(
  parameter int N_SRC = 4,
  parameter int DW    = 32,
  parameter int BURST = 4
) (
  input  logic                okClk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_avail,
  input  logic [N_SRC-1:0]    src_valid,
  input  logic [N_SRC*DW-1:0] src_data,
  output logic [N_SRC-1:0]    src_ready,
  input  logic                pipe_out_read,
  output logic [DW-1:0]       pipe_out_data,
  output logic                busy,
  output logic [7:0]          grant_id,
  output logic [31:0]         frames_sent,
  output logic                underflow_err
);

  localparam logic [16:0]   BURST_W   = 17'(BURST);
  localparam logic [DW-1:0] IDLE_WORD = '0;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t        state, state_nxt;
  logic [7:0]    rr_ptr, rr_ptr_nxt;
  logic [7:0]    grant_nxt;
  logic [16:0]   beat_cnt, beat_cnt_nxt;
  logic [DW-1:0] data_nxt;
  logic [31:0]   frames_nxt;
  logic          underflow_nxt;

  logic [7:0]    win_hi, win_lo, winner;
  logic          win_hi_vld, win_lo_vld;
  logic [DW-1:0] head_word;
  logic          head_vld;
  logic          pop;

  // Descending scans leave the lowest match: win_hi is the first at/above rr_ptr, win_lo handles the wrap.
  always_comb begin
    win_hi     = '0;
    win_lo     = '0;
    win_hi_vld = 1'b0;
    win_lo_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_avail[i]) begin
        win_lo     = 8'(i);
        win_lo_vld = 1'b1;
        if (8'(i) >= rr_ptr) begin
          win_hi     = 8'(i);
          win_hi_vld = 1'b1;
        end
      end
    end
    winner = win_hi_vld ? win_hi : win_lo;
  end

  always_comb begin
    head_word = '0;
    head_vld  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (8'(i) == grant_id) begin
        head_word = src_data[i*DW +: DW];
        head_vld  = src_valid[i];
      end
    end
  end

  assign pop  = pipe_out_read && ((state == HDR) || ((state == DATA) && (beat_cnt < BURST_W)));
  assign busy = (state != IDLE);

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = pop && (8'(i) == grant_id);
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    beat_cnt_nxt  = beat_cnt;
    data_nxt      = pipe_out_data;
    frames_nxt    = frames_sent;
    underflow_nxt = underflow_err | (pop & ~head_vld);
    case (state)
      IDLE: begin
        if (win_lo_vld) begin
          grant_nxt = winner;
          data_nxt  = {1'b1, 7'b0, winner, BURST_W[15:0]};
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (pipe_out_read) begin
          data_nxt     = head_word;
          beat_cnt_nxt = 17'd1;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (pipe_out_read) begin
          if (beat_cnt < BURST_W) begin
            data_nxt     = head_word;
            beat_cnt_nxt = beat_cnt + 17'd1;
          end else begin
            data_nxt     = IDLE_WORD;
            beat_cnt_nxt = '0;
            frames_nxt   = frames_sent + 32'd1;
            rr_ptr_nxt   = (grant_id == 8'(N_SRC - 1)) ? 8'd0 : grant_id + 8'd1;
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      beat_cnt      <= '0;
      pipe_out_data <= IDLE_WORD;
      frames_sent   <= '0;
      underflow_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      grant_id      <= grant_nxt;
      beat_cnt      <= beat_cnt_nxt;
      pipe_out_data <= data_nxt;
      frames_sent   <= frames_nxt;
      underflow_err <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_out_burst_arbiter.sv
// Scoreboarded bench: tests push expected host words, a negedge monitor compares every read.
module tb_pipe_out_burst_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int B  = 4;

  logic          okClk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  src_avail = '0;
  logic [N-1:0]  src_valid;
  logic [N-1:0]  src_ready;
  logic [N-1:0]  vmask = '0;
  logic [N*DW-1:0] src_data;
  logic          pipe_out_read = 1'b0;
  logic [DW-1:0] pipe_out_data;
  logic          busy;
  logic [7:0]    grant_id;
  logic [31:0]   frames_sent;
  logic          underflow_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int sptr[N];
  int pops[N];
  int eptr[N];

  always #5 okClk = ~okClk;

  pipe_out_burst_arbiter #(.N_SRC(N), .DW(DW), .BURST(B)) dut (
    .okClk(okClk), .rst(rst),
    .src_avail(src_avail), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .pipe_out_read(pipe_out_read), .pipe_out_data(pipe_out_data),
    .busy(busy), .grant_id(grant_id), .frames_sent(frames_sent), .underflow_err(underflow_err)
  );

  function automatic logic [31:0] word_of(input int s, input int k);
    if (s == 2) return 32'h11 + k;
    return 32'h101 + 32'h100 * s + k;
  endfunction

  function automatic logic [31:0] hdr_of(input int s);
    return 32'h8000_0000 | (32'(s) << 16) | 32'(B);
  endfunction

  // FWFT source models: head word comes from a per-source pointer advanced on src_ready.
  always_comb begin
    src_data  = '0;
    src_valid = '0;
    for (int s = 0; s < N; s++) begin
      src_data[s*DW +: DW] = word_of(s, sptr[s]);
      src_valid[s]         = ~vmask[s];
    end
  end

  always @(posedge okClk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N; s++) begin
        sptr[s] <= 0;
        pops[s] <= 0;
      end
    end else begin
      for (int s = 0; s < N; s++) begin
        if (src_ready[s]) begin
          sptr[s] <= sptr[s] + 1;
          pops[s] <= pops[s] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge okClk) begin
    if (!rst && pipe_out_read) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra actual=%h required=none", pipe_out_data);
      end else begin
        chk("stream", pipe_out_data, exp_q.pop_front());
      end
      chk("ready_onehot", 32'($countones(src_ready) <= 1), 32'd1);
    end
  end

  task automatic push_idle();
    exp_q.push_back(32'h0);
  endtask

  task automatic push_frame(input int s);
    exp_q.push_back(hdr_of(s));
    for (int k = 0; k < B; k++) begin
      exp_q.push_back(word_of(s, eptr[s]));
      eptr[s]++;
    end
  endtask

  task automatic rd(input int gap, input bit stab);
    logic [31:0] v;
    pipe_out_read = 1'b1;
    @(posedge okClk);
    #1;
    pipe_out_read = 1'b0;
    v = pipe_out_data;
    for (int g = 0; g < gap; g++) begin
      @(posedge okClk);
      #1;
      if (stab) chk("stable_between_reads", pipe_out_data, v);
    end
  endtask

  task automatic rd_n(input int n);
    for (int r = 0; r < n; r++) rd(0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pipe_out_read = 1'b0;
    src_avail = '0;
    vmask = '0;
    @(posedge okClk);
    #1;
    chk("rst_data", pipe_out_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_frames", frames_sent, 32'd0);
    chk("rst_underflow", 32'(underflow_err), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    for (int s = 0; s < N; s++) eptr[s] = 0;
    exp_q.delete();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Single source, continuous reads
    do_reset();
    push_idle(); push_frame(2); push_idle();
    src_avail = 4'b0100;
    rd_n(2);
    src_avail = '0;
    rd_n(5);
    chk("t1_frames", frames_sent, 32'd1);
    chk("t1_pops2", 32'(pops[2]), 32'd4);
    chk("t1_grant", 32'(grant_id), 32'd2);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Round-robin fairness over five frames
    do_reset();
    for (int f = 0; f < 5; f++) begin
      push_idle();
      push_frame(f % 4);
    end
    src_avail = 4'b1111;
    rd_n(30);
    src_avail = '0;
    chk("t2_frames", frames_sent, 32'd5);
    chk("t2_pops0", 32'(pops[0]), 32'd8);
    chk("t2_pops1", 32'(pops[1]), 32'd4);
    chk("t2_pops2", 32'(pops[2]), 32'd4);
    chk("t2_pops3", 32'(pops[3]), 32'd4);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // Avail dropped mid-frame: frame completes, no regrant
    do_reset();
    push_idle(); push_frame(1); push_idle(); push_idle();
    src_avail = 4'b0010;
    rd_n(3);
    src_avail = '0;
    rd_n(5);
    chk("t3_frames", frames_sent, 32'd1);
    chk("t3_pops1", 32'(pops[1]), 32'd4);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // Sparse reads give the same word sequence
    do_reset();
    push_idle(); push_frame(2); push_idle();
    src_avail = 4'b0100;
    rd($urandom_range(0, 4), 1'b1);
    rd($urandom_range(0, 4), 1'b1);
    src_avail = '0;
    for (int r = 0; r < 5; r++) rd($urandom_range(0, 4), 1'b1);
    chk("t4_frames", frames_sent, 32'd1);
    chk("t4_pops2", 32'(pops[2]), 32'd4);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // Underflow on the third pop is sticky across frames
    do_reset();
    push_idle(); push_frame(0); push_idle(); push_frame(0);
    src_avail = 4'b0001;
    rd_n(3);
    chk("t5_no_underflow_yet", 32'(underflow_err), 32'd0);
    vmask = 4'b0001;
    rd_n(1);
    vmask = '0;
    chk("t5_underflow_set", 32'(underflow_err), 32'd1);
    rd_n(8);
    src_avail = '0;
    chk("t5_underflow_sticky", 32'(underflow_err), 32'd1);
    chk("t5_frames", frames_sent, 32'd2);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame truncates and restarts at source 0
    do_reset();
    push_idle(); push_frame(0); push_idle();
    exp_q.push_back(hdr_of(1));
    exp_q.push_back(word_of(1, 0));
    exp_q.push_back(word_of(1, 1));
    src_avail = 4'b0011;
    rd_n(10);
    chk("t6_pre_frames", frames_sent, 32'd1);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    chk("t6_pre_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_data", pipe_out_data, 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_frames", frames_sent, 32'd0);
    chk("t6_rst_grant", 32'(grant_id), 32'd0);
    @(posedge okClk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < N; s++) eptr[s] = 0;
    push_idle(); push_frame(0);
    rd_n(6);
    src_avail = '0;
    chk("t6_post_frames", frames_sent, 32'd1);
    chk("t6_post_grant", 32'(grant_id), 32'd0);
    chk("t6_post_drained", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge okClk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
